// File: rtl/store_buffer_if.sv
// Store buffer interface bundle.
// Groups the pipeline-side store/load handshake and the memory-port signals
// that connect a store_buffer to the pipeline and the unified memory.
//   slave  : the store buffer itself (takes requests, drives memory port)
//   master : the surrounding pipeline/memory side
// Signals:
//   st_valid/st_ready/st_addr/st_data : store request channel
//   ld_valid/ld_addr/ld_data/ld_stall : load request channel
//   mem_we/mem_addr/mem_wd/mem_rd     : memory port (combinational read)
//   empty/count                       : occupancy status
interface store_buffer_if #(
  parameter int BYTE_SIZE  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4
);
  localparam int DW = BYTE_SIZE * 8;
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  st_valid;
  logic                  st_ready;
  logic [ADDR_WIDTH-1:0] st_addr;
  logic [DW-1:0]         st_data;
  logic                  ld_valid;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [DW-1:0]         ld_data;
  logic                  ld_stall;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DW-1:0]         mem_wd;
  logic [DW-1:0]         mem_rd;
  logic                  empty;
  logic [CW-1:0]         count;

  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_rd,
    output st_ready, ld_data, ld_stall, mem_we, mem_addr, mem_wd, empty, count
  );

  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_rd,
    input  st_ready, ld_data, ld_stall, mem_we, mem_addr, mem_wd, empty, count
  );
endinterface

// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and a byte-addressed unified memory with
// combinational read, posedge write and one shared address.
// Stores are queued in a circular FIFO and drained one per cycle whenever the
// memory port is not claimed by a completing load. Loads that exactly match
// the youngest overlapping buffered store are forwarded from the buffer; loads
// that only partially overlap stall until that store has drained.
// Ports:
//   clk   : clock, all state updates on posedge
//   reset : asynchronous active-high reset of pointers and occupancy
//   sb    : store_buffer_if.slave (store/load channels, memory port, status)
module store_buffer #(
  parameter int BYTE_SIZE  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input logic           clk,
  input logic           reset,
  store_buffer_if.slave sb
);
  localparam int DW = BYTE_SIZE * 8;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [CW-1:0]         cnt;
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DW-1:0]         data_q [DEPTH];

  logic                  y_found;
  logic [PW-1:0]         y_idx;
  logic [PW-1:0]         scan_idx;
  logic                  y_exact;
  logic                  ld_done;
  logic                  drain;
  logic                  push;

  // Two BYTE_SIZE-wide accesses overlap when either start lies within the
  // other's range; modular subtraction makes ranges that straddle the top of
  // the address space count as well.
  function automatic logic overlaps(input logic [ADDR_WIDTH-1:0] a,
                                    input logic [ADDR_WIDTH-1:0] b);
    logic [ADDR_WIDTH-1:0] d_fwd;
    logic [ADDR_WIDTH-1:0] d_bwd;
    d_fwd = a - b;
    d_bwd = b - a;
    return (d_fwd < ADDR_WIDTH'(BYTE_SIZE)) || (d_bwd < ADDR_WIDTH'(BYTE_SIZE));
  endfunction

  // Scan occupied entries oldest to youngest; the last hit is the youngest
  // overlapping store. Only registered entries take part, so a store being
  // pushed this cycle is invisible to a same-cycle load.
  always_comb begin
    y_found  = 1'b0;
    y_idx    = head;
    scan_idx = head;
    for (int age = 0; age < DEPTH; age++) begin
      scan_idx = head + PW'(age);
      if ((CW'(age) < cnt) && overlaps(sb.ld_addr, addr_q[scan_idx])) begin
        y_found = 1'b1;
        y_idx   = scan_idx;
      end
    end
  end

  assign y_exact  = y_found && (addr_q[y_idx] == sb.ld_addr);
  assign sb.ld_stall = sb.ld_valid && y_found && !y_exact;
  assign ld_done  = sb.ld_valid && !sb.ld_stall;

  // The memory port belongs to a completing load; otherwise the oldest entry
  // drains. A stalled load therefore hands the port to the drain.
  assign drain    = (cnt != '0) && !ld_done;
  assign sb.st_ready = (cnt != CW'(DEPTH));
  assign push     = sb.st_valid && sb.st_ready;

  assign sb.mem_we   = drain;
  assign sb.mem_addr = drain ? addr_q[head] : sb.ld_addr;
  assign sb.mem_wd   = drain ? data_q[head] : '0;
  assign sb.ld_data  = (sb.ld_valid && y_exact) ? data_q[y_idx] : sb.mem_rd;
  assign sb.empty    = (cnt == '0);
  assign sb.count    = cnt;

  // Control state: asynchronous reset so mem_we drops the moment reset rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push)  tail <= tail + 1'b1;
      if (drain) head <= head + 1'b1;
      case ({push, drain})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry payload needs no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= sb.st_addr;
      data_q[tail] <= sb.st_data;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: a small byte-addressed memory model,
// a table of single-cycle vectors with hand-computed expectations, and
// hand-written sequences for fill/ordered drain and reset mid-drain.
module tb_store_buffer;
  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   wr_cnt = 0;
  logic [7:0] mem [0:511] = '{default: 8'h00};

  store_buffer_if #(.BYTE_SIZE(4), .ADDR_WIDTH(32), .DEPTH(4)) sbif ();

  store_buffer #(.BYTE_SIZE(4), .ADDR_WIDTH(32), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sbif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read, posedge write, address folded to 512 B.
  always_comb begin
    sbif.mem_rd = '0;
    for (int k = 0; k < 4; k++)
      sbif.mem_rd[8*k +: 8] = mem[9'(sbif.mem_addr + 32'(k))];
  end

  always @(posedge clk) begin
    if (sbif.mem_we) begin
      for (int k = 0; k < 4; k++)
        mem[9'(sbif.mem_addr + 32'(k))] <= sbif.mem_wd[8*k +: 8];
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        st_v;
    logic [31:0] st_a;
    logic [31:0] st_d;
    logic        ld_v;
    logic [31:0] ld_a;
    logic        chk_ld;
    logic [31:0] e_ld;
    logic        e_stall;
    logic        e_we;
    logic [31:0] e_maddr;
    logic [31:0] e_wd;
    int          e_cnt;
  } vec_t;

  function automatic vec_t mkv(logic sv, logic [31:0] sa, logic [31:0] sd,
                               logic lv, logic [31:0] la, logic cl, logic [31:0] eld,
                               logic es, logic ew, logic [31:0] ema, logic [31:0] ewd,
                               int ec);
    vec_t v;
    v.st_v = sv; v.st_a = sa; v.st_d = sd; v.ld_v = lv; v.ld_a = la;
    v.chk_ld = cl; v.e_ld = eld; v.e_stall = es; v.e_we = ew;
    v.e_maddr = ema; v.e_wd = ewd; v.e_cnt = ec;
    return v;
  endfunction

  vec_t vt [21];

  task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic lv, input logic [31:0] la);
    sbif.st_valid = sv;
    sbif.st_addr  = sa;
    sbif.st_data  = sd;
    sbif.ld_valid = lv;
    sbif.ld_addr  = la;
  endtask

  logic [31:0] drain_a [5];
  logic [31:0] drain_d [5];
  int          saved_wr;

  initial begin
    //        st  st_addr       st_data       ld  ld_addr      chk ld_data       stall we  mem_addr      mem_wd        cnt
    vt[0]  = mkv(0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0,        0);
    vt[1]  = mkv(1, 32'h10,       32'hDEADBEEF, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0,        0);
    vt[2]  = mkv(0, 32'h0,        32'h0,        1, 32'h10,       1, 32'hDEADBEEF, 0, 0, 32'h10,       32'h0,        1);
    vt[3]  = mkv(0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h0,        0, 1, 32'h10,       32'hDEADBEEF, 1);
    vt[4]  = mkv(1, 32'h10,       32'h1,        1, 32'h100,      1, 32'h0,        0, 0, 32'h100,      32'h0,        0);
    vt[5]  = mkv(1, 32'h10,       32'h2,        1, 32'h100,      1, 32'h0,        0, 0, 32'h100,      32'h0,        1);
    vt[6]  = mkv(0, 32'h0,        32'h0,        1, 32'h10,       1, 32'h2,        0, 0, 32'h10,       32'h0,        2);
    vt[7]  = mkv(0, 32'h0,        32'h0,        1, 32'h12,       0, 32'h0,        1, 1, 32'h10,       32'h1,        2);
    vt[8]  = mkv(0, 32'h0,        32'h0,        1, 32'h12,       0, 32'h0,        1, 1, 32'h10,       32'h2,        1);
    vt[9]  = mkv(0, 32'h0,        32'h0,        1, 32'h12,       1, 32'h0,        0, 0, 32'h12,       32'h0,        0);
    vt[10] = mkv(1, 32'h10,       32'h44332211, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0,        0);
    vt[11] = mkv(0, 32'h0,        32'h0,        1, 32'h12,       0, 32'h0,        1, 1, 32'h10,       32'h44332211, 1);
    vt[12] = mkv(0, 32'h0,        32'h0,        1, 32'h12,       1, 32'h00004433, 0, 0, 32'h12,       32'h0,        0);
    vt[13] = mkv(1, 32'hFFFFFFFE, 32'hA5A5A5A5, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0,        0);
    vt[14] = mkv(0, 32'h0,        32'h0,        1, 32'h2,        1, 32'h0,        0, 0, 32'h2,        32'h0,        1);
    vt[15] = mkv(0, 32'h0,        32'h0,        1, 32'hFFFFFFFA, 1, 32'h0,        0, 0, 32'hFFFFFFFA, 32'h0,        1);
    vt[16] = mkv(0, 32'h0,        32'h0,        1, 32'h0,        0, 32'h0,        1, 1, 32'hFFFFFFFE, 32'hA5A5A5A5, 1);
    vt[17] = mkv(0, 32'h0,        32'h0,        1, 32'h0,        1, 32'h0000A5A5, 0, 0, 32'h0,        32'h0,        0);
    vt[18] = mkv(1, 32'hFFFFFFFE, 32'h5A5A5A5A, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0,        0);
    vt[19] = mkv(0, 32'h0,        32'h0,        1, 32'hFFFFFFFB, 0, 32'h0,        1, 1, 32'hFFFFFFFE, 32'h5A5A5A5A, 1);
    vt[20] = mkv(0, 32'h0,        32'h0,        1, 32'hFFFFFFFC, 1, 32'h5A5A0000, 0, 0, 32'hFFFFFFFC, 32'h0,        0);

    // Reset state
    reset = 1'b1;
    drive(0, 32'h0, 32'h0, 0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    #2;
    chk("rst.count",    32'(sbif.count), 32'd0);
    chk("rst.st_ready", 32'(sbif.st_ready), 32'd1);
    chk("rst.empty",    32'(sbif.empty), 32'd1);
    chk("rst.mem_we",   32'(sbif.mem_we), 32'd0);
    chk("rst.ld_stall", 32'(sbif.ld_stall), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven single-cycle vectors
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      drive(vt[i].st_v, vt[i].st_a, vt[i].st_d, vt[i].ld_v, vt[i].ld_a);
      #2;
      chk($sformatf("v%0d.ld_stall", i), 32'(sbif.ld_stall), 32'(vt[i].e_stall));
      chk($sformatf("v%0d.mem_we", i),   32'(sbif.mem_we),   32'(vt[i].e_we));
      chk($sformatf("v%0d.mem_addr", i), sbif.mem_addr,      vt[i].e_maddr);
      chk($sformatf("v%0d.mem_wd", i),   sbif.mem_wd,        vt[i].e_wd);
      chk($sformatf("v%0d.count", i),    32'(sbif.count),    32'(vt[i].e_cnt));
      chk($sformatf("v%0d.empty", i),    32'(sbif.empty),    32'(vt[i].e_cnt == 0));
      chk($sformatf("v%0d.st_ready", i), 32'(sbif.st_ready), 32'(vt[i].e_cnt != 4));
      if (vt[i].chk_ld)
        chk($sformatf("v%0d.ld_data", i), sbif.ld_data, vt[i].e_ld);
    end

    // Fill behind a non-overlapping load, then ordered drain with a held 5th store
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1, 32'(4 * i), 32'hC0DE0000 + 32'(i), 1, 32'h100);
      #2;
      chk($sformatf("fill%0d.ld_stall", i), 32'(sbif.ld_stall), 32'd0);
      chk($sformatf("fill%0d.mem_we", i),   32'(sbif.mem_we), 32'd0);
      chk($sformatf("fill%0d.st_ready", i), 32'(sbif.st_ready), 32'd1);
    end
    @(negedge clk);
    drive(1, 32'h20, 32'h55555555, 1, 32'h100);
    #2;
    chk("full.st_ready", 32'(sbif.st_ready), 32'd0);
    chk("full.count",    32'(sbif.count), 32'd4);
    chk("full.mem_we",   32'(sbif.mem_we), 32'd0);
    drain_a = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h20};
    drain_d = '{32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003, 32'h55555555};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) sbif.ld_valid = 1'b0;
      if (i == 2) sbif.st_valid = 1'b0;
      #2;
      chk($sformatf("drain%0d.mem_we", i),   32'(sbif.mem_we), 32'd1);
      chk($sformatf("drain%0d.mem_addr", i), sbif.mem_addr, drain_a[i]);
      chk($sformatf("drain%0d.mem_wd", i),   sbif.mem_wd, drain_d[i]);
      if (i == 0) chk("drain0.st_ready", 32'(sbif.st_ready), 32'd0);
      if (i == 1) chk("drain1.st_ready", 32'(sbif.st_ready), 32'd1);
    end
    @(negedge clk);
    #2;
    chk("drained.empty",  32'(sbif.empty), 32'd1);
    chk("drained.mem_we", 32'(sbif.mem_we), 32'd0);
    chk("drained.mem4",   {mem[7], mem[6], mem[5], mem[4]}, 32'hC0DE0001);

    // Reset asserted mid-drain
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1, 32'h40 + 32'(4 * i), 32'h77000000 + 32'(i), 1, 32'h100);
    end
    @(negedge clk);
    drive(0, 32'h0, 32'h0, 0, 32'h0);
    #2;
    chk("mid.mem_we", 32'(sbif.mem_we), 32'd1);
    chk("mid.count",  32'(sbif.count), 32'd3);
    saved_wr = wr_cnt;
    #1 reset = 1'b1;
    #1;
    chk("rstmid.mem_we",   32'(sbif.mem_we), 32'd0);
    chk("rstmid.count",    32'(sbif.count), 32'd0);
    chk("rstmid.empty",    32'(sbif.empty), 32'd1);
    chk("rstmid.st_ready", 32'(sbif.st_ready), 32'd1);
    chk("rstmid.ld_stall", 32'(sbif.ld_stall), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #2;
      chk($sformatf("post%0d.mem_we", i), 32'(sbif.mem_we), 32'd0);
    end
    chk("post.writes", 32'(wr_cnt), 32'(saved_wr));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
